// File: rtl/fpnew_opgroup_result_arbiter.sv
// rtl/fpnew_opgroup_result_arbiter.sv - per-channel result FIFOs merged onto one output stream
// Each channel buffers FifoDepth results; a round-robin or fixed-priority arbiter with grant lock drains them.
module fpnew_opgroup_result_arbiter #(
  parameter int NumIn     = 5,
  parameter int DataWidth = 38,
  parameter int FifoDepth = 2,
  parameter int ArbMode   = 0,
  localparam int IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1,
  localparam int CntWidth = $clog2(FifoDepth + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [NumIn-1:0]              in_valid_i,
  output logic [NumIn-1:0]              in_ready_o,
  input  logic [NumIn*DataWidth-1:0]    in_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DataWidth-1:0]          out_data_o,
  output logic [IdxWidth-1:0]           out_idx_o,
  output logic [NumIn*CntWidth-1:0]     fill_o,
  output logic                          busy_o
);

  localparam int PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  logic [NumIn-1:0]           w_nonempty;
  logic [NumIn-1:0]           w_push;
  logic [NumIn-1:0]           w_pop;
  logic [NumIn*DataWidth-1:0] w_head;
  logic                       w_out_valid;
  logic                       w_hs;
  logic                       w_found;
  logic [IdxWidth-1:0]        w_arb_idx;
  logic [IdxWidth-1:0]        w_grant;
  logic [DataWidth-1:0]       w_sel_data;
  logic [IdxWidth-1:0]        r_rr_ptr;
  logic [IdxWidth-1:0]        r_lock_idx;
  logic                       r_locked;

  for (genvar g = 0; g < NumIn; g++) begin : g_ch
    logic [DataWidth-1:0] r_mem [FifoDepth];
    logic [PtrWidth-1:0]  r_rd_ptr;
    logic [PtrWidth-1:0]  r_wr_ptr;
    logic [CntWidth-1:0]  r_fill;

    // Ready depends only on registered occupancy, so a full FIFO refuses even while being popped.
    assign in_ready_o[g] = (r_fill != CntWidth'(FifoDepth)) & ~flush_i;
    assign w_push[g]     = in_valid_i[g] & in_ready_o[g];
    assign w_pop[g]      = w_hs & (w_grant == IdxWidth'(g));
    assign w_nonempty[g] = (r_fill != '0);
    assign fill_o[g*CntWidth +: CntWidth]   = r_fill;
    assign w_head[g*DataWidth +: DataWidth] = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_fill   <= '0;
      end else begin
        if (w_push[g]) begin
          r_wr_ptr <= (r_wr_ptr == PtrWidth'(FifoDepth - 1)) ? '0 : r_wr_ptr + PtrWidth'(1);
        end
        if (w_pop[g]) begin
          r_rd_ptr <= (r_rd_ptr == PtrWidth'(FifoDepth - 1)) ? '0 : r_rd_ptr + PtrWidth'(1);
        end
        r_fill <= r_fill + CntWidth'(w_push[g]) - CntWidth'(w_pop[g]);
      end
    end

    always_ff @(posedge clk_i) begin
      if (w_push[g]) begin
        r_mem[r_wr_ptr] <= in_data_i[g*DataWidth +: DataWidth];
      end
    end
  end

  assign w_out_valid = (|w_nonempty) & ~flush_i & rst_ni;
  assign w_hs        = w_out_valid & out_ready_i;

  always_comb begin
    w_arb_idx = '0;
    w_found   = 1'b0;
    if (ArbMode == 0) begin
      for (int k = 0; k < NumIn; k++) begin
        if (!w_found && w_nonempty[(int'(r_rr_ptr) + k) % NumIn]) begin
          w_arb_idx = IdxWidth'((int'(r_rr_ptr) + k) % NumIn);
          w_found   = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < NumIn; k++) begin
        if (!w_found && w_nonempty[k]) begin
          w_arb_idx = IdxWidth'(k);
          w_found   = 1'b1;
        end
      end
    end
  end

  // A stalled grant stays put so the downstream sees a stable word until it takes it.
  assign w_grant = r_locked ? r_lock_idx : w_arb_idx;

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NumIn; k++) begin
      if (w_grant == IdxWidth'(k)) begin
        w_sel_data = w_head[k*DataWidth +: DataWidth];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_rr_ptr   <= '0;
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_hs) begin
      r_locked <= 1'b0;
      r_rr_ptr <= (w_grant == IdxWidth'(NumIn - 1)) ? '0 : w_grant + IdxWidth'(1);
    end else if (w_out_valid) begin
      r_locked   <= 1'b1;
      r_lock_idx <= w_grant;
    end
  end

  assign out_valid_o = w_out_valid;
  assign out_data_o  = w_out_valid ? w_sel_data : '0;
  assign out_idx_o   = w_out_valid ? w_grant : '0;
  assign busy_o      = w_out_valid;

endmodule

// File: tb/tb_fpnew_opgroup_result_arbiter.sv
// tb/tb_fpnew_opgroup_result_arbiter.sv - scoreboard bench for the opgroup result arbiter
// Instance a is round-robin, instance b is fixed priority; both use NumIn=5, depth 2.
module tb_fpnew_opgroup_result_arbiter;

  localparam int N  = 5;
  localparam int DW = 38;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  logic [N-1:0]    a_valid, a_ready_in, b_valid, b_ready_in;
  logic [N*DW-1:0] a_din, b_din;
  logic            a_out_valid, a_out_ready, a_busy;
  logic            b_out_valid, b_out_ready, b_busy;
  logic [DW-1:0]   a_dout, b_dout;
  logic [2:0]      a_idx, b_idx;
  logic [N*CW-1:0] a_fill, b_fill;

  logic [40:0] qa[$];
  logic [40:0] qb[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpnew_opgroup_result_arbiter #(.NumIn(N), .DataWidth(DW), .FifoDepth(2), .ArbMode(0)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(a_valid), .in_ready_o(a_ready_in), .in_data_i(a_din),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_dout),
    .out_idx_o(a_idx), .fill_o(a_fill), .busy_o(a_busy)
  );

  fpnew_opgroup_result_arbiter #(.NumIn(N), .DataWidth(DW), .FifoDepth(2), .ArbMode(1)) u_fp (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(b_valid), .in_ready_o(b_ready_in), .in_data_i(b_din),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_dout),
    .out_idx_o(b_idx), .fill_o(b_fill), .busy_o(b_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input int ch, input logic [DW-1:0] d);
    a_valid[ch] = 1'b1;
    a_din[ch*DW +: DW] = d;
  endtask

  task automatic drive_b(input int ch, input logic [DW-1:0] d);
    b_valid[ch] = 1'b1;
    b_din[ch*DW +: DW] = d;
  endtask

  function automatic logic [CW-1:0] fa(input int ch);
    return a_fill[ch*CW +: CW];
  endfunction

  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rr_unexpected: got idx %0d data %0h expected nothing", a_idx, a_dout);
      end else begin
        check("rr_out", {a_idx, a_dout}, qa.pop_front());
      end
    end
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL fp_unexpected: got idx %0d data %0h expected nothing", b_idx, b_dout);
      end else begin
        check("fp_out", {b_idx, b_dout}, qb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    a_valid = '0; a_din = '0; a_out_ready = 1'b0;
    b_valid = '0; b_din = '0; b_out_ready = 1'b0;
    step(2);
    check("rst_valid", a_out_valid, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_fill", a_fill, '0);
    check("rst_ready", a_ready_in, 5'h1f);
    check("rst_ready_b", b_ready_in, 5'h1f);
    rst_n = 1'b1;
    step(1);

    // three channels at once drain in index order
    a_out_ready = 1'b1;
    drive_a(0, 38'h10_0000_0000); drive_a(2, 38'h20_0000_0002); drive_a(4, 38'h30_0000_0004);
    qa.push_back({3'd0, 38'h10_0000_0000});
    qa.push_back({3'd2, 38'h20_0000_0002});
    qa.push_back({3'd4, 38'h30_0000_0004});
    #1 check("s1_no_fallthru", a_out_valid, 1'b0);
    step(1); a_valid = '0;
    check("s1_latency", {a_out_valid, a_idx}, {1'b1, 3'd0});
    step(3);
    check("s1_drained", a_out_valid, 1'b0);

    // stall locks channel 3 even after channel 0 fills
    a_out_ready = 1'b0;
    drive_a(3, 38'h03_3333_3333);
    qa.push_back({3'd3, 38'h03_3333_3333});
    qa.push_back({3'd0, 38'h00_AAAA_0000});
    step(1); a_valid = '0; drive_a(0, 38'h00_AAAA_0000);
    step(1); a_valid = '0;
    check("s2_stall1", {a_idx, a_dout}, {3'd3, 38'h03_3333_3333});
    step(1);
    check("s2_stall2", {a_idx, a_dout}, {3'd3, 38'h03_3333_3333});
    check("s2_fill0", fa(0), 2'd1);
    a_out_ready = 1'b1;
    step(1);
    check("s2_next", a_idx, 3'd0);
    step(1);
    check("s2_drained", a_out_valid, 1'b0);

    // channel 1 fills to depth, third word refused
    a_out_ready = 1'b0;
    drive_a(1, 38'h11_0000_000A);
    qa.push_back({3'd1, 38'h11_0000_000A});
    qa.push_back({3'd1, 38'h11_0000_000B});
    qa.push_back({3'd1, 38'h11_0000_000C});
    step(1); drive_a(1, 38'h11_0000_000B);
    step(1);
    check("s3_ready_full", a_ready_in[1], 1'b0);
    check("s3_fill2", fa(1), 2'd2);
    drive_a(1, 38'h11_0000_000C);
    step(1);
    check("s3_fill_hold", fa(1), 2'd2);

    // pop of a full FIFO does not admit the held push in the same cycle
    a_out_ready = 1'b1;
    #1 check("s4_ready_pop", a_ready_in[1], 1'b0);
    step(1);
    check("s4_fill1", fa(1), 2'd1);
    check("s4_ready_back", a_ready_in[1], 1'b1);
    step(1); a_valid = '0;
    check("s4_pushpop", fa(1), 2'd1);
    step(1);
    check("s4_empty", {a_out_valid, fa(1)}, {1'b0, 2'd0});

    // flush with two full channels and a concurrent push
    a_out_ready = 1'b0;
    drive_a(0, 38'h0E_0000_0000); drive_a(4, 38'h0E_0000_0004);
    step(1); drive_a(0, 38'h0E_0000_0001); drive_a(4, 38'h0E_0000_0005);
    step(1); a_valid = '0;
    check("s5_fill04", {fa(0), fa(4)}, {2'd2, 2'd2});
    flush = 1'b1;
    drive_a(2, 38'h0F_0000_0002);
    #1 check("s5_flush_valid", a_out_valid, 1'b0);
    check("s5_flush_ready", a_ready_in, 5'h00);
    step(1); flush = 1'b0; a_valid = '0;
    check("s5_fill_clear", a_fill, '0);
    check("s5_idle", {a_out_valid, a_busy}, 2'b00);
    a_out_ready = 1'b1;
    drive_a(1, 38'h01_0000_0001); drive_a(3, 38'h03_0000_0003);
    qa.push_back({3'd1, 38'h01_0000_0001});
    qa.push_back({3'd3, 38'h03_0000_0003});
    step(1); a_valid = '0;
    check("s5_rr_zero", a_idx, 3'd1);
    step(2);
    check("s5_drained", a_out_valid, 1'b0);

    // reset mid-transfer discards buffered data
    a_out_ready = 1'b0;
    drive_a(2, 38'h02_DEAD_0002);
    step(1); a_valid = '0;
    check("rst_pre_fill", fa(2), 2'd1);
    rst_n = 1'b0;
    #1 check("rst_mid_valid", a_out_valid, 1'b0);
    step(1);
    check("rst_mid_fill", a_fill, '0);
    rst_n = 1'b1;
    step(1);
    check("rst_release", {a_out_valid, a_ready_in}, {1'b0, 5'h1f});

    // fixed priority: channel 1 keeps winning while non-empty
    drive_b(1, 38'h21_0000_0000); drive_b(3, 38'h23_0000_0000);
    qb.push_back({3'd1, 38'h21_0000_0000});
    qb.push_back({3'd1, 38'h21_0000_0001});
    qb.push_back({3'd1, 38'h21_0000_0002});
    qb.push_back({3'd3, 38'h23_0000_0000});
    qb.push_back({3'd3, 38'h23_0000_0001});
    step(1); drive_b(1, 38'h21_0000_0001); drive_b(3, 38'h23_0000_0001);
    step(1); b_valid = '0;
    check("fp_first", b_idx, 3'd1);
    b_out_ready = 1'b1;
    step(1); drive_b(1, 38'h21_0000_0002);
    step(1); b_valid = '0;
    check("fp_still1", b_idx, 3'd1);
    step(1);
    check("fp_then3", b_idx, 3'd3);
    step(2);
    check("fp_drained", b_out_valid, 1'b0);

    step(2);
    check("rr_queue_empty", qa.size(), 0);
    check("fp_queue_empty", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
